cbfp_0: RTL

CBFP_0 -- requirements
Module: cbfp_0

---
 rtl/cbfp_0.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cbfp_0.sv
// Convergent block floating point stage: collects 4-beat blocks of 16 complex lanes,
// finds the common leading-sign headroom, and replays the block normalized through a ping-pong buffer.

module cbfp_0_lane #(
  parameter int IN_W  = 23,
  parameter int OUT_W = 11,
  parameter int LW    = 5
) (
  input  logic signed [IN_W-1:0]  i_re,
  input  logic signed [IN_W-1:0]  i_im,
  output logic        [LW-1:0]    o_lsc,
  input  logic signed [IN_W-1:0]  i_rd_re,
  input  logic signed [IN_W-1:0]  i_rd_im,
  input  logic        [LW-1:0]    i_shift,
  output logic signed [OUT_W-1:0] o_re,
  output logic signed [OUT_W-1:0] o_im
);
  localparam int MAX_SHIFT = IN_W - OUT_W;

  function automatic logic [LW-1:0] lsc(input logic [IN_W-1:0] x);
    logic [LW-1:0] n;
    logic          stop;
    n    = '0;
    stop = 1'b0;
    for (int i = IN_W-2; i >= 0; i--) begin
      if (!stop) begin
        if (x[i] == x[IN_W-1]) n = n + LW'(1);
        else stop = 1'b1;
      end
    end
    return n;
  endfunction

  logic [LW-1:0]          w_lsc_re, w_lsc_im;
  logic signed [IN_W-1:0] w_sh_re, w_sh_im;

  assign w_lsc_re = lsc(i_re);
  assign w_lsc_im = lsc(i_im);
  assign o_lsc    = (w_lsc_re < w_lsc_im) ? w_lsc_re : w_lsc_im;

  // shift never exceeds headroom, so the top OUT_W bits carry the whole value
  assign w_sh_re = i_rd_re <<< i_shift;
  assign w_sh_im = i_rd_im <<< i_shift;
  assign o_re    = OUT_W'(w_sh_re >>> MAX_SHIFT);
  assign o_im    = OUT_W'(w_sh_im >>> MAX_SHIFT);
endmodule

module cbfp_0 #(
  parameter int IN_W  = 23,
  parameter int OUT_W = 11
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [IN_W-1:0]  in_re  [0:15],
  input  logic signed [IN_W-1:0]  in_im  [0:15],
  input  logic                    in_valid,
  output logic signed [OUT_W-1:0] out_re [0:15],
  output logic signed [OUT_W-1:0] out_im [0:15],
  output logic [3:0]              out_exp,
  output logic                    out_valid,
  output logic [1:0]              out_beat
);
  localparam int MAX_SHIFT = IN_W - OUT_W;
  localparam int LW        = $clog2(IN_W);
  localparam logic [LW-1:0] MAX_S = LW'(MAX_SHIFT);

  logic signed [IN_W-1:0] r_buf_re [0:1][0:3][0:15];
  logic signed [IN_W-1:0] r_buf_im [0:1][0:3][0:15];

  logic [1:0]    r_wbeat;
  logic          r_wbank;
  logic [LW-1:0] r_min;
  logic [LW-1:0] r_s;
  logic          r_rd_act;
  logic [1:0]    r_rd_cnt;
  logic          r_rd_bank;

  logic [LW-1:0]          w_lsc   [0:15];
  logic signed [IN_W-1:0] w_rd_re [0:15];
  logic signed [IN_W-1:0] w_rd_im [0:15];
  logic signed [OUT_W-1:0] w_nrm_re [0:15];
  logic signed [OUT_W-1:0] w_nrm_im [0:15];
  logic [LW-1:0] w_beat_min, w_blk_min, w_s;
  logic          w_blk_done;

  for (genvar l = 0; l < 16; l++) begin : g_lane
    assign w_rd_re[l] = r_buf_re[r_rd_bank][r_rd_cnt][l];
    assign w_rd_im[l] = r_buf_im[r_rd_bank][r_rd_cnt][l];
    cbfp_0_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .LW(LW)) u_lane (
      .i_re    (in_re[l]),
      .i_im    (in_im[l]),
      .o_lsc   (w_lsc[l]),
      .i_rd_re (w_rd_re[l]),
      .i_rd_im (w_rd_im[l]),
      .i_shift (r_s),
      .o_re    (w_nrm_re[l]),
      .o_im    (w_nrm_im[l])
    );
  end

  always_comb begin
    w_beat_min = w_lsc[0];
    for (int l = 1; l < 16; l++)
      if (w_lsc[l] < w_beat_min) w_beat_min = w_lsc[l];
  end

  assign w_blk_min  = (r_wbeat == 2'd0 || r_min < w_beat_min) ?
                      ((r_wbeat == 2'd0) ? w_beat_min : r_min) : w_beat_min;
  assign w_s        = (w_blk_min < MAX_S) ? w_blk_min : MAX_S;
  assign w_blk_done = in_valid && (r_wbeat == 2'd3);

  // buffer is plain storage; stale contents are never read before being rewritten
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int l = 0; l < 16; l++) begin
        r_buf_re[r_wbank][r_wbeat][l] <= in_re[l];
        r_buf_im[r_wbank][r_wbeat][l] <= in_im[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wbeat   <= '0;
      r_wbank   <= 1'b0;
      r_min     <= '0;
      r_s       <= '0;
      r_rd_act  <= 1'b0;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      if (in_valid) begin
        r_wbeat <= r_wbeat + 2'd1;
        r_min   <= w_blk_min;
      end
      // a completing block can only arrive once the previous readout is on its last beat
      if (w_blk_done) begin
        r_wbank   <= ~r_wbank;
        r_s       <= w_s;
        r_rd_act  <= 1'b1;
        r_rd_cnt  <= '0;
        r_rd_bank <= r_wbank;
      end else if (r_rd_act) begin
        r_rd_cnt <= r_rd_cnt + 2'd1;
        if (r_rd_cnt == 2'd3) r_rd_act <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_exp   <= '0;
      out_beat  <= '0;
      for (int l = 0; l < 16; l++) begin
        out_re[l] <= '0;
        out_im[l] <= '0;
      end
    end else begin
      out_valid <= r_rd_act;
      if (r_rd_act) begin
        out_exp  <= 4'(r_s);
        out_beat <= r_rd_cnt;
        for (int l = 0; l < 16; l++) begin
          out_re[l] <= w_nrm_re[l];
          out_im[l] <= w_nrm_im[l];
        end
      end
    end
  end
endmodule
